// File: rtl/seq_det_pkg.sv
// Shared helpers for the parametrised pattern detector: prefix-automaton
// construction functions evaluated at elaboration and the state-width helper.
package seq_det_pkg;

    localparam int MAX_PAT_W = 16;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_STEP,
        ACT_MATCH
    } act_e;

    function automatic int state_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // Pattern bit i in arrival order lives at pattern[pat_w-1-i].
    function automatic int fail_len(input logic [MAX_PAT_W-1:0] pattern, input int pat_w);
        int r;
        bit ok;
        r = 0;
        for (int j = 1; j < pat_w; j++) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
                if (pattern[pat_w-1-i] != pattern[j-1-i]) ok = 1'b0;
            end
            if (ok) r = j;
        end
        return r;
    endfunction

    function automatic int next_len(input logic [MAX_PAT_W-1:0] pattern, input int pat_w,
                                    input int k, input logic b);
        int r;
        int sp;
        bit ok;
        logic sbit;
        r = 0;
        for (int j = 1; j <= k + 1; j++) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
                sp   = k + 1 - j + i;
                sbit = (sp < k) ? pattern[pat_w-1-sp] : b;
                if (pattern[pat_w-1-i] != sbit) ok = 1'b0;
            end
            if (ok) r = j;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_det_sat_counter.sv
// Saturating match counter; clear wins over a simultaneous increment.
module seq_det_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    assign sat = &count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Serial detector for a compile-time PATTERN using a prefix-length automaton
// whose transition table is built at elaboration.
//
//   state        | meaning
//   0            | no pattern bits matched
//   1..PAT_W-1   | that many leading pattern bits matched
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1001,
    parameter int               CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      x,
    input  logic                      x_valid,
    input  logic                      overlap,
    input  logic                      clr_count,
    output logic                      y,
    output logic [state_w(PAT_W)-1:0] state,
    output logic [CNT_W-1:0]          match_count,
    output logic                      count_sat
);

    localparam int                   SW      = state_w(PAT_W);
    localparam int                   TBL_N   = 2 ** SW;
    localparam logic [MAX_PAT_W-1:0] PAT_EXT = MAX_PAT_W'(PATTERN);
    localparam int                   FAIL    = fail_len(PAT_EXT, PAT_W);

    // Entry {k, bit} holds delta(k, bit); unreachable k rows are tied to zero.
    logic [2*TBL_N-1:0][SW-1:0] nxt_tbl;

    for (genvar gk = 0; gk < TBL_N; gk++) begin : g_k
        for (genvar gb = 0; gb < 2; gb++) begin : g_b
            if (gk < PAT_W) begin : g_live
                localparam int NX = next_len(PAT_EXT, PAT_W, gk, 1'(gb));
                assign nxt_tbl[2*gk+gb] = SW'(NX);
            end else begin : g_dead
                assign nxt_tbl[2*gk+gb] = '0;
            end
        end
    end

    act_e          act;
    logic [SW-1:0] j;
    logic [SW-1:0] state_d;
    logic          y_d;

    always_comb begin
        act     = ACT_HOLD;
        j       = nxt_tbl[{state, x}];
        state_d = state;
        y_d     = 1'b0;
        if (x_valid) begin
            if (j == SW'(PAT_W)) begin
                act     = ACT_MATCH;
                y_d     = 1'b1;
                state_d = overlap ? SW'(FAIL) : '0;
            end else begin
                act     = ACT_STEP;
                state_d = j;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= '0;
            y     <= 1'b0;
        end else begin
            state <= state_d;
            y     <= y_d;
        end
    end

    seq_det_sat_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (act == ACT_MATCH),
        .clr   (clr_count),
        .count (match_count),
        .sat   (count_sat)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: three configurations share one stimulus
// stream and are checked against a history-based reference model.
module tb_seq_detector_param;

    logic clk = 1'b0;
    logic rst_n;
    logic x, x_valid, overlap, clr_count;

    logic       y_a, sat_a;
    logic [2:0] state_a;
    logic [7:0] cnt_a;
    logic       y_b, sat_b;
    logic [2:0] state_b;
    logic [1:0] cnt_b;
    logic       y_c, sat_c;
    logic [1:0] state_c;
    logic [7:0] cnt_c;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1001), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .overlap(overlap),
        .clr_count(clr_count), .y(y_a), .state(state_a), .match_count(cnt_a),
        .count_sat(sat_a));

    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1001), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .overlap(overlap),
        .clr_count(clr_count), .y(y_b), .state(state_b), .match_count(cnt_b),
        .count_sat(sat_b));

    seq_detector_param #(.PAT_W(2), .PATTERN(2'b00), .CNT_W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .overlap(overlap),
        .clr_count(clr_count), .y(y_c), .state(state_c), .match_count(cnt_c),
        .count_sat(sat_c));

    // Model: keep the valid bits since the last reset/non-overlap match; k is the
    // longest pattern prefix (< PAT_W) that ends the history.
    logic [15:0] m_pat [3];
    int          m_pw  [3];
    int          m_cw  [3];
    logic [31:0] m_h   [3];
    int          m_n   [3];
    int          m_k   [3];
    int          m_c   [3];
    logic        m_y   [3];

    function automatic int longest(input logic [15:0] pat, input int pw,
                                   input logic [31:0] h, input int n, input int maxj);
        int r;
        bit ok;
        r = 0;
        for (int jj = 1; jj <= maxj; jj++) begin
            if (jj > n) break;
            ok = 1'b1;
            for (int i = 0; i < jj; i++) begin
                if (h[jj-1-i] !== pat[pw-1-i]) ok = 1'b0;
            end
            if (ok) r = jj;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_h[d] = '0; m_n[d] = 0; m_k[d] = 0; m_c[d] = 0; m_y[d] = 1'b0;
        end
    endtask

    task automatic model_edge(input logic xb, input logic v, input logic ov, input logic clr);
        bit match;
        for (int d = 0; d < 3; d++) begin
            match  = 1'b0;
            m_y[d] = 1'b0;
            if (v) begin
                m_h[d] = {m_h[d][30:0], xb};
                m_n[d] = (m_n[d] < 32) ? m_n[d] + 1 : 32;
                if (longest(m_pat[d], m_pw[d], m_h[d], m_n[d], m_pw[d]) == m_pw[d]) match = 1'b1;
                if (match) begin
                    m_y[d] = 1'b1;
                    if (!ov) m_n[d] = 0;
                end
                m_k[d] = longest(m_pat[d], m_pw[d], m_h[d], m_n[d], m_pw[d] - 1);
            end
            if (clr) m_c[d] = 0;
            else if (match && m_c[d] < (1 << m_cw[d]) - 1) m_c[d] = m_c[d] + 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("a_state", 32'(state_a), 32'(m_k[0]));
        chk("a_y",     32'(y_a),     32'(m_y[0]));
        chk("a_count", 32'(cnt_a),   32'(m_c[0]));
        chk("a_sat",   32'(sat_a),   32'(m_c[0] == 255));
        chk("b_state", 32'(state_b), 32'(m_k[1]));
        chk("b_y",     32'(y_b),     32'(m_y[1]));
        chk("b_count", 32'(cnt_b),   32'(m_c[1]));
        chk("b_sat",   32'(sat_b),   32'(m_c[1] == 3));
        chk("c_state", 32'(state_c), 32'(m_k[2]));
        chk("c_y",     32'(y_c),     32'(m_y[2]));
        chk("c_count", 32'(cnt_c),   32'(m_c[2]));
        chk("c_sat",   32'(sat_c),   32'(m_c[2] == 255));
    endtask

    task automatic step(input logic xb, input logic v, input logic ov, input logic clr);
        x = xb; x_valid = v; overlap = ov; clr_count = clr;
        @(posedge clk);
        model_edge(xb, v, ov, clr);
        #1;
        check_all();
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n, input logic ov);
        for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, ov, 1'b0);
    endtask

    // Asynchronous reset applied between edges; outputs must clear immediately.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        m_pat[0] = 16'b1001; m_pw[0] = 4; m_cw[0] = 8;
        m_pat[1] = 16'b1001; m_pw[1] = 4; m_cw[1] = 2;
        m_pat[2] = 16'b00;   m_pw[2] = 2; m_cw[2] = 8;
        x = 1'b0; x_valid = 1'b0; overlap = 1'b0; clr_count = 1'b0;
        rst_n = 1'b1;
        #2;
        do_reset();

        send_bits(32'b1001001, 7, 1'b0);
        chk("tp_nonovl_count", 32'(cnt_a), 32'd1);
        chk("tp_nonovl_state", 32'(state_a), 32'd1);

        do_reset();
        send_bits(32'b1001001, 7, 1'b1);
        chk("tp_ovl_count", 32'(cnt_a), 32'd2);

        do_reset();
        send_bits(32'b101001, 6, 1'b0);
        chk("tp_recover_count", 32'(cnt_a), 32'd1);

        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("tp_gap_state", 32'(state_a), 32'd2);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("tp_gap_count", 32'(cnt_a), 32'd1);

        do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (6) send_bits(32'b001, 3, 1'b1);
        chk("tp_sat_count", 32'(cnt_b), 32'd3);
        chk("tp_sat_flag", 32'(sat_b), 32'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("tp_clr_count", 32'(cnt_b), 32'd0);
        chk("tp_clr_y", 32'(y_b), 32'd1);

        do_reset();
        send_bits(32'b100, 3, 1'b0);
        chk("tp_mid_pre_state", 32'(state_a), 32'd3);
        do_reset();
        chk("tp_mid_state", 32'(state_a), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("tp_mid_post_state", 32'(state_a), 32'd1);
        chk("tp_mid_post_y", 32'(y_a), 32'd0);

        do_reset();
        send_bits(32'b1000100, 7, 1'b1);
        chk("tp_pred_count", 32'(cnt_c), 32'd3);

        do_reset();
        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 9) < 8),
                     1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 99) < 3));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
